// File: rtl/sc_instr_encoder_loader_pkg.sv
// Shared widths, state encoding and format-3 field positions for the
// instruction encoder/loader and the IR decode side.
package sc_instr_encoder_loader_pkg;

  localparam int unsigned DATAWIDTH_BUS                  = 32;
  localparam int unsigned DATAWIDTH_SCRATCHPAD_DIRECTION = 5;
  localparam int unsigned DATAWIDTH_DECODEROP            = 8;
  localparam int unsigned DATAWIDTH_SIMM                 = 13;
  localparam int unsigned DATAWIDTH_ADDR                 = 8;
  localparam int unsigned DATAWIDTH_COUNT                = DATAWIDTH_ADDR + 1;

  // Format-3 field positions
  localparam int unsigned FIELD_OP_HI   = 31;
  localparam int unsigned FIELD_OP_LO   = 30;
  localparam int unsigned FIELD_RD_HI   = 29;
  localparam int unsigned FIELD_RD_LO   = 25;
  localparam int unsigned FIELD_OP3_HI  = 24;
  localparam int unsigned FIELD_OP3_LO  = 19;
  localparam int unsigned FIELD_RS1_HI  = 18;
  localparam int unsigned FIELD_RS1_LO  = 14;
  localparam int unsigned FIELD_I_BIT   = 13;
  localparam int unsigned FIELD_SIMM_HI = 12;
  localparam int unsigned FIELD_SIMM_LO = 0;
  localparam int unsigned FIELD_RS2_HI  = 4;
  localparam int unsigned FIELD_RS2_LO  = 0;

  typedef enum logic [2:0] {
    STATE_IDLE   = 3'd0,
    STATE_ACCEPT = 3'd1,
    STATE_WRITE  = 3'd2,
    STATE_DONE   = 3'd3,
    STATE_ERROR  = 3'd4
  } encoderState_t;

endpackage

// File: rtl/sc_instr_encoder_loader_pack.sv
// Combinational field-to-word packer for format-3 instructions.
module sc_instr_pack
  import sc_instr_encoder_loader_pkg::*;
(
  input  logic [DATAWIDTH_DECODEROP-1:0]            ops,
  input  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] rd,
  input  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] rs1,
  input  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] rs2,
  input  logic                                      bit13,
  input  logic [DATAWIDTH_SIMM-1:0]                 simm,
  output logic [DATAWIDTH_BUS-1:0]                  instrWord_c
);

  always_comb begin
    instrWord_c = '0;
    instrWord_c[FIELD_OP_HI:FIELD_OP_LO]   = ops[7:6];
    instrWord_c[FIELD_RD_HI:FIELD_RD_LO]   = rd;
    instrWord_c[FIELD_OP3_HI:FIELD_OP3_LO] = ops[5:0];
    instrWord_c[FIELD_RS1_HI:FIELD_RS1_LO] = rs1;
    instrWord_c[FIELD_I_BIT]               = bit13;
    // Register form leaves bits 12:5 zero
    if (bit13) begin
      instrWord_c[FIELD_SIMM_HI:FIELD_SIMM_LO] = simm;
    end else begin
      instrWord_c[FIELD_RS2_HI:FIELD_RS2_LO] = rs2;
    end
  end

endmodule

// File: rtl/sc_instr_encoder_loader.sv
// Accepts instruction field tuples, packs them and writes them sequentially
// into program memory over a write/ack port.
module sc_instr_encoder_loader
  import sc_instr_encoder_loader_pkg::*;
(
  input  logic                                      SC_InstrEncoder_CLOCK_50,
  input  logic                                      SC_InstrEncoder_RESET_InLow,
  input  logic                                      SC_InstrEncoder_start_In,
  input  logic [DATAWIDTH_ADDR-1:0]                 SC_InstrEncoder_baseAddr_InBus,
  input  logic                                      SC_InstrEncoder_valid_In,
  input  logic                                      SC_InstrEncoder_last_In,
  input  logic [DATAWIDTH_DECODEROP-1:0]            SC_InstrEncoder_OPS_InBus,
  input  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] SC_InstrEncoder_RDestino_InBus,
  input  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] SC_InstrEncoder_RS1_InBus,
  input  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] SC_InstrEncoder_RS2_InBus,
  input  logic                                      SC_InstrEncoder_BIT13_In,
  input  logic [DATAWIDTH_SIMM-1:0]                 SC_InstrEncoder_SIMM_InBus,
  output logic                                      SC_InstrEncoder_ready_Out,
  output logic                                      SC_InstrEncoder_memWr_Out,
  output logic [DATAWIDTH_ADDR-1:0]                 SC_InstrEncoder_memAddr_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                  SC_InstrEncoder_memData_OutBus,
  input  logic                                      SC_InstrEncoder_memAck_In,
  output logic                                      SC_InstrEncoder_busy_Out,
  output logic                                      SC_InstrEncoder_done_Out,
  output logic                                      SC_InstrEncoder_err_Out,
  output logic [DATAWIDTH_COUNT-1:0]                SC_InstrEncoder_count_OutBus
);

  encoderState_t               stateQ, stateNext;
  logic [DATAWIDTH_ADDR-1:0]   addrQ, addrNext;
  logic [DATAWIDTH_BUS-1:0]    dataQ, dataNext;
  logic [DATAWIDTH_COUNT-1:0]  countQ, countNext;
  logic                        lastQ, lastNext;
  logic                        readyQ, readyNext;
  logic                        memWrQ, memWrNext;
  logic                        busyQ, busyNext;
  logic                        doneQ, doneNext;
  logic                        errQ, errNext;
  logic [DATAWIDTH_BUS-1:0]    packedWord_c;

  sc_instr_pack u_pack (
    .ops         (SC_InstrEncoder_OPS_InBus),
    .rd          (SC_InstrEncoder_RDestino_InBus),
    .rs1         (SC_InstrEncoder_RS1_InBus),
    .rs2         (SC_InstrEncoder_RS2_InBus),
    .bit13       (SC_InstrEncoder_BIT13_In),
    .simm        (SC_InstrEncoder_SIMM_InBus),
    .instrWord_c (packedWord_c)
  );

  // State and output registers; outputs are loaded from their next-state decode
  always_ff @(posedge SC_InstrEncoder_CLOCK_50) begin
    if (!SC_InstrEncoder_RESET_InLow) begin
      stateQ <= STATE_IDLE;
      addrQ  <= '0;
      dataQ  <= '0;
      countQ <= '0;
      lastQ  <= 1'b0;
      readyQ <= 1'b0;
      memWrQ <= 1'b0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateNext;
      addrQ  <= addrNext;
      dataQ  <= dataNext;
      countQ <= countNext;
      lastQ  <= lastNext;
      readyQ <= readyNext;
      memWrQ <= memWrNext;
      busyQ  <= busyNext;
      doneQ  <= doneNext;
      errQ   <= errNext;
    end
  end

  always_comb begin
    stateNext = stateQ;
    addrNext  = addrQ;
    dataNext  = dataQ;
    countNext = countQ;
    lastNext  = lastQ;

    unique case (stateQ)
      STATE_IDLE, STATE_ERROR: begin
        if (SC_InstrEncoder_start_In) begin
          stateNext = STATE_ACCEPT;
          addrNext  = SC_InstrEncoder_baseAddr_InBus;
          countNext = '0;
        end
      end
      STATE_ACCEPT: begin
        if (SC_InstrEncoder_valid_In) begin
          stateNext = STATE_WRITE;
          dataNext  = packedWord_c;
          lastNext  = SC_InstrEncoder_last_In;
        end
      end
      STATE_WRITE: begin
        // Address wrap past all-ones is an overflow, not a silent rollover
        if (SC_InstrEncoder_memAck_In) begin
          countNext = DATAWIDTH_COUNT'(countQ + 1'b1);
          if (lastQ) begin
            stateNext = STATE_DONE;
          end else if (addrQ == '1) begin
            stateNext = STATE_ERROR;
          end else begin
            stateNext = STATE_ACCEPT;
            addrNext  = DATAWIDTH_ADDR'(addrQ + 1'b1);
          end
        end
      end
      STATE_DONE: stateNext = STATE_IDLE;
      default:    stateNext = STATE_IDLE;
    endcase

    readyNext = (stateNext == STATE_ACCEPT);
    memWrNext = (stateNext == STATE_WRITE);
    busyNext  = (stateNext == STATE_ACCEPT) || (stateNext == STATE_WRITE);
    doneNext  = (stateNext == STATE_DONE);
    errNext   = (stateNext == STATE_ERROR);
  end

  assign SC_InstrEncoder_ready_Out      = readyQ;
  assign SC_InstrEncoder_memWr_Out      = memWrQ;
  assign SC_InstrEncoder_memAddr_OutBus = addrQ;
  assign SC_InstrEncoder_memData_OutBus = dataQ;
  assign SC_InstrEncoder_busy_Out       = busyQ;
  assign SC_InstrEncoder_done_Out       = doneQ;
  assign SC_InstrEncoder_err_Out        = errQ;
  assign SC_InstrEncoder_count_OutBus   = countQ;

endmodule

// File: tb/tb_sc_instr_encoder_loader.sv
// Directed self-checking bench for sc_instr_encoder_loader.
module tb_sc_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [7:0]  baseAddr;
  logic        valid;
  logic        last;
  logic [7:0]  ops;
  logic [4:0]  rd, rs1, rs2;
  logic        bit13;
  logic [12:0] simm;
  logic        ready, memWr, memAck, busy, done, err;
  logic [7:0]  memAddr;
  logic [31:0] memData;
  logic [8:0]  count;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  sc_instr_encoder_loader dut (
    .SC_InstrEncoder_CLOCK_50       (clk),
    .SC_InstrEncoder_RESET_InLow    (rstN),
    .SC_InstrEncoder_start_In       (start),
    .SC_InstrEncoder_baseAddr_InBus (baseAddr),
    .SC_InstrEncoder_valid_In       (valid),
    .SC_InstrEncoder_last_In        (last),
    .SC_InstrEncoder_OPS_InBus      (ops),
    .SC_InstrEncoder_RDestino_InBus (rd),
    .SC_InstrEncoder_RS1_InBus      (rs1),
    .SC_InstrEncoder_RS2_InBus      (rs2),
    .SC_InstrEncoder_BIT13_In       (bit13),
    .SC_InstrEncoder_SIMM_InBus     (simm),
    .SC_InstrEncoder_ready_Out      (ready),
    .SC_InstrEncoder_memWr_Out      (memWr),
    .SC_InstrEncoder_memAddr_OutBus (memAddr),
    .SC_InstrEncoder_memData_OutBus (memData),
    .SC_InstrEncoder_memAck_In      (memAck),
    .SC_InstrEncoder_busy_Out       (busy),
    .SC_InstrEncoder_done_Out       (done),
    .SC_InstrEncoder_err_Out        (err),
    .SC_InstrEncoder_count_OutBus   (count)
  );

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic setTuple(input logic [7:0] o, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic i, input logic [12:0] im,
                          input logic l);
    valid = 1'b1; ops = o; rd = d; rs1 = s1; rs2 = s2; bit13 = i; simm = im; last = l;
  endtask

  task automatic startSession(input logic [7:0] base);
    start = 1'b1; baseAddr = base;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 0; baseAddr = 0; valid = 0; last = 0; ops = 0;
    rd = 0; rs1 = 0; rs2 = 0; bit13 = 0; simm = 0; memAck = 0;
    tick(); tick();
    testsRun++;
    if ({ready, memWr, busy, done, err} !== 5'b00000) begin
      testsFailed++;
      $display("FAIL reset_flags got=%b exp=00000", {ready, memWr, busy, done, err});
    end
    testsRun++;
    if ({memAddr, memData, count} !== 49'd0) begin
      testsFailed++;
      $display("FAIL reset_buses addr=%h data=%h count=%0d exp all zero", memAddr, memData, count);
    end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    startSession(8'h10);
    testsRun++;
    if ({ready, busy, memWr} !== 3'b110) begin
      testsFailed++;
      $display("FAIL single_accept ready/busy/memWr got=%b exp=110", {ready, busy, memWr});
    end
    setTuple(8'h80, 5'd1, 5'd2, 5'd3, 1'b0, 13'h0AB, 1'b1);
    tick();
    valid = 1'b0;
    testsRun++;
    if ({memWr, ready, memAddr, memData} !== {2'b10, 8'h10, 32'h82008003}) begin
      testsFailed++;
      $display("FAIL single_write memWr=%b ready=%b addr=%h data=%h exp 1 0 10 82008003",
               memWr, ready, memAddr, memData);
    end
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    testsRun++;
    if ({memWr, done, busy, count} !== {3'b010, 9'd1}) begin
      testsFailed++;
      $display("FAIL single_done memWr=%b done=%b busy=%b count=%0d exp 0 1 0 1",
               memWr, done, busy, count);
    end
    tick();
    testsRun++;
    if ({done, memAddr, count} !== {1'b0, 8'h10, 9'd1}) begin
      testsFailed++;
      $display("FAIL single_idle done=%b addr=%h count=%0d exp 0 10 1", done, memAddr, count);
    end
  endtask

  task automatic test_immediate();
    startSession(8'h30);
    setTuple(8'h80, 5'd1, 5'd1, 5'h1F, 1'b1, 13'h1FFF, 1'b1);
    tick();
    valid = 1'b0;
    testsRun++;
    if (memData !== 32'h82007FFF) begin
      testsFailed++;
      $display("FAIL imm_pack data got=%h exp=82007fff", memData);
    end
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] expData [3];
    expData[0] = 32'h02000007;
    expData[1] = 32'h44080000;
    expData[2] = 32'hC7FFE0AA;
    startSession(8'h20);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: setTuple(8'h00, 5'd1, 5'd0,  5'd7, 1'b0, 13'h1FFF, 1'b0);
        1: setTuple(8'h41, 5'd2, 5'd0,  5'd0, 1'b0, 13'h0000, 1'b0);
        default: setTuple(8'hFF, 5'd3, 5'd31, 5'd9, 1'b1, 13'h00AA, 1'b1);
      endcase
      tick();
      valid = 1'b0;
      for (int w = 0; w < 3; w++) begin
        testsRun++;
        if ({memWr, ready, memAddr, memData} !== {2'b10, 8'(8'h20 + k), expData[k]}) begin
          testsFailed++;
          $display("FAIL b2b_hold word%0d wait%0d memWr=%b ready=%b addr=%h data=%h exp addr=%h data=%h",
                   k, w, memWr, ready, memAddr, memData, 8'(8'h20 + k), expData[k]);
        end
        tick();
      end
      memAck = 1'b1;
      tick();
      memAck = 1'b0;
      if (k < 2) begin
        testsRun++;
        if ({ready, memWr, count} !== {2'b10, 9'(k + 1)}) begin
          testsFailed++;
          $display("FAIL b2b_reaccept word%0d ready=%b memWr=%b count=%0d exp 1 0 %0d",
                   k, ready, memWr, count, k + 1);
        end
      end
    end
    testsRun++;
    if ({done, count, memAddr} !== {1'b1, 9'd3, 8'h22}) begin
      testsFailed++;
      $display("FAIL b2b_done done=%b count=%0d addr=%h exp 1 3 22", done, count, memAddr);
    end
    tick();
  endtask

  task automatic test_overflow();
    startSession(8'hFF);
    setTuple(8'h80, 5'd1, 5'd2, 5'd3, 1'b0, 13'h0, 1'b0);
    tick();
    valid = 1'b0;
    testsRun++;
    if ({memWr, memAddr} !== {1'b1, 8'hFF}) begin
      testsFailed++;
      $display("FAIL ovf_write memWr=%b addr=%h exp 1 ff", memWr, memAddr);
    end
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    setTuple(8'h80, 5'd4, 5'd4, 5'd4, 1'b0, 13'h0, 1'b1);
    tick();
    tick();
    valid = 1'b0;
    testsRun++;
    if ({err, ready, busy, memWr, count} !== {4'b1000, 9'd1}) begin
      testsFailed++;
      $display("FAIL ovf_error err=%b ready=%b busy=%b memWr=%b count=%0d exp 1 0 0 0 1",
               err, ready, busy, memWr, count);
    end
    startSession(8'h05);
    testsRun++;
    if ({err, ready, memAddr, count} !== {2'b01, 8'h05, 9'd0}) begin
      testsFailed++;
      $display("FAIL ovf_restart err=%b ready=%b addr=%h count=%0d exp 0 1 05 0",
               err, ready, memAddr, count);
    end
    setTuple(8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 13'h0, 1'b1);
    tick();
    valid = 1'b0;
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    startSession(8'h40);
    setTuple(8'h80, 5'd1, 5'd2, 5'd3, 1'b0, 13'h0, 1'b1);
    tick();
    valid = 1'b0;
    testsRun++;
    if (memWr !== 1'b1) begin
      testsFailed++;
      $display("FAIL rstmid_prewrite memWr got=%b exp=1", memWr);
    end
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    testsRun++;
    if ({memWr, busy, ready, count} !== {3'b000, 9'd0}) begin
      testsFailed++;
      $display("FAIL rstmid_abort memWr=%b busy=%b ready=%b count=%0d exp 0 0 0 0",
               memWr, busy, ready, count);
    end
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    tick();
    testsRun++;
    if ({memWr, busy, ready, done, count} !== {4'b0000, 9'd0}) begin
      testsFailed++;
      $display("FAIL rstmid_lateack memWr=%b busy=%b ready=%b done=%b count=%0d exp all 0",
               memWr, busy, ready, done, count);
    end
  endtask

  task automatic test_ignored_events();
    startSession(8'h50);
    startSession(8'h60);
    testsRun++;
    if ({ready, busy, memAddr, count} !== {2'b11, 8'h50, 9'd0}) begin
      testsFailed++;
      $display("FAIL ign_start ready=%b busy=%b addr=%h count=%0d exp 1 1 50 0",
               ready, busy, memAddr, count);
    end
    setTuple(8'h80, 5'd1, 5'd2, 5'd3, 1'b0, 13'h0, 1'b1);
    tick();
    valid = 1'b0;
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    tick();
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    tick();
    testsRun++;
    if ({ready, busy, memWr, done, memAddr, count} !== {4'b0000, 8'h50, 9'd1}) begin
      testsFailed++;
      $display("FAIL ign_ack ready=%b busy=%b memWr=%b done=%b addr=%h count=%0d exp 0 0 0 0 50 1",
               ready, busy, memWr, done, memAddr, count);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_immediate();
    test_back_to_back();
    test_overflow();
    test_reset_mid_write();
    test_ignored_events();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sc_instr_encoder_loader.md
Name: sc_instr_encoder_loader

Overview:
Inverse of the instruction-register field decode. Accepts instruction fields (rd, rs1, rs2, op/op3, i-bit, simm13) over a valid/ready handshake, packs them into a 32-bit format-3 word and writes the words sequentially into program memory through a write/ack port. Used by the boot/debug path to load programs into the datapath's instruction memory.

Parameters:
DATAWIDTH_BUS, 32, instruction/memory data width
DATAWIDTH_SCRATCHPAD_DIRECTION, 5, register-address field width (rd, rs1, rs2)
DATAWIDTH_DECODEROP, 8, packed opcode {op[1:0], op3[5:0]}
DATAWIDTH_SIMM, 13, immediate field width
DATAWIDTH_ADDR, 8, program-memory address width

Ports:
SC_InstrEncoder_CLOCK_50  in  1  system clock; the only clock
SC_InstrEncoder_RESET_InLow  in  1  synchronous reset, active-low
SC_InstrEncoder_start_In  in  1  one-cycle pulse; begin a load session at base address
SC_InstrEncoder_baseAddr_InBus  in  DATAWIDTH_ADDR  first write address, sampled on start
SC_InstrEncoder_valid_In  in  1  field tuple valid
SC_InstrEncoder_last_In  in  1  tuple is the final instruction of the session
SC_InstrEncoder_OPS_InBus  in  DATAWIDTH_DECODEROP  {op, op3}
SC_InstrEncoder_RDestino_InBus  in  DATAWIDTH_SCRATCHPAD_DIRECTION  rd
SC_InstrEncoder_RS1_InBus  in  DATAWIDTH_SCRATCHPAD_DIRECTION  rs1
SC_InstrEncoder_RS2_InBus  in  DATAWIDTH_SCRATCHPAD_DIRECTION  rs2
SC_InstrEncoder_BIT13_In  in  1  i-bit (1 = immediate)
SC_InstrEncoder_SIMM_InBus  in  DATAWIDTH_SIMM  simm13
SC_InstrEncoder_ready_Out  out  1  tuple accepted when valid & ready
SC_InstrEncoder_memWr_Out  out  1  memory write request
SC_InstrEncoder_memAddr_OutBus  out  DATAWIDTH_ADDR  write address
SC_InstrEncoder_memData_OutBus  out  DATAWIDTH_BUS  packed instruction
SC_InstrEncoder_memAck_In  in  1  memory write complete
SC_InstrEncoder_busy_Out  out  1  session in progress
SC_InstrEncoder_done_Out  out  1  one-cycle pulse, session completed
SC_InstrEncoder_err_Out  out  1  sticky address-overflow error
SC_InstrEncoder_count_OutBus  out  DATAWIDTH_ADDR+1  words written this session

Behaviour:
- Reset (RESET_InLow=0 at a clock edge): state IDLE; all outputs 0 (ready, memWr, memAddr, memData, busy, done, err, count). Reset mid-session aborts immediately; a pending write is dropped; no ack is awaited.
- Packing: [31:30]=OPS[7:6]; [29:25]=rd; [24:19]=OPS[5:0]; [18:14]=rs1; [13]=BIT13; [12:0]=SIMM when BIT13=1, else {8'b0, rs2}. Unused inputs ignored.
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE: ready=0, busy=0. start=1 -> ACCEPT; addr<=baseAddr, count<=0, err<=0.
- ACCEPT: ready=1, busy=1. valid=1 -> capture packed word and last flag; go to WRITE.
- WRITE: ready=0, memWr=1; addr/data held stable until ack. Ack may arrive in the first WRITE cycle (single-cycle memory). On ack: count++. If last -> DONE. Else if addr is all-ones -> ERROR. Else addr++ and go to ACCEPT.
- DONE: done=1 for exactly one cycle; busy=0; then IDLE. memAddr holds the last written address.
- ERROR: err=1 (sticky); busy=0; ready=0. start=1 -> ACCEPT with err cleared.
- Throughput: one word per 2 cycles minimum (ACCEPT + 1-cycle WRITE).
- Ignored events: start outside IDLE/ERROR; ack outside WRITE; valid outside ACCEPT.
- memWr, memAddr, memData, ready, done and busy are registered. No combinational path from any input to any output.

Decomposition:
- Shared package: state encoding constants; field bit positions (RD 29:25, OP 31:30, OP3 24:19, RS1 18:14, I 13, SIMM 12:0, RS2 4:0). The IR decode side reuses the same constants.
- Sub-module: sc_instr_pack, a purely combinational field-to-word packer, reusable by the testbench as a golden model.

Test Plan:
- start, base=0x10; one tuple OPS=8'h80, rd=1, rs1=2, i=0, rs2=3, last=1; ack in the first WRITE cycle -> memWr one cycle, addr=0x10, data=0x82008003; done pulses; count=1.
- i=1, rd=1, rs1=1, OPS=8'h80, SIMM=13'h1FFF, rs2=5'h1F -> data=0x82007FFF (rs2 ignored).
- Three tuples, base=0x20; ack delayed 3 cycles each -> addr/data stable while memWr=1; writes at 0x20, 0x21, 0x22; ready low during WRITE; count=3.
- base=0xFF; two tuples with last=0 on the first -> first written at 0xFF, then ERROR, err=1, ready=0; a new start clears err.
- Reset asserted during WRITE before ack -> next cycle memWr=0, busy=0, count=0; later ack ignored; state IDLE.
- start pulsed during ACCEPT, and ack pulsed in IDLE -> no effect on addr, count or state.
